// File: rtl/rf_cmd_pkg.sv
// Shared opcodes, state encoding and defaults for the register-file command controller.
package rf_cmd_pkg;

  localparam logic [7:0] RF_WR_CMD = 8'hAA;
  localparam logic [7:0] RF_RD_CMD = 8'hBB;
  localparam int RD_TIMEOUT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/rf_cmd_ctrl.sv
// Parses framed write/read commands from the UART receiver, drives the register
// file strobes and forwards read data to the UART transmitter.
module rf_cmd_ctrl
  import rf_cmd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR       = 4,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic             RF_WrEn,
  output logic             RF_RdEn,
  output logic [ADDR-1:0]  RF_Address,
  output logic [WIDTH-1:0] RF_WrData,
  input  logic [WIDTH-1:0] RF_RdData,
  input  logic             RF_RdData_VLD,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             TX_Busy,
  output logic             CMD_ERR,
  output state_e           dbg_state
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  state_e           state_q, state_n;
  logic             wr_en_q, wr_en_n;
  logic             rd_en_q, rd_en_n;
  logic             tx_vld_q, tx_vld_n;
  logic             err_q, err_n;
  logic [ADDR-1:0]  addr_q, addr_n;
  logic [WIDTH-1:0] wdata_q, wdata_n;
  logic [WIDTH-1:0] txd_q, txd_n;
  logic [WIDTH-1:0] hold_q, hold_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             addr_ok;

  assign addr_ok = 32'(RX_P_DATA) < DEPTH;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      txd_q    <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      wr_en_q  <= wr_en_n;
      rd_en_q  <= rd_en_n;
      tx_vld_q <= tx_vld_n;
      err_q    <= err_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      txd_q    <= txd_n;
      hold_q   <= hold_n;
      cnt_q    <= cnt_n;
    end
  end

  // TX handshake: a byte is offered only on an edge where TX_Busy is low; TX_D_VLD
  // then pulses for one cycle with TX_P_DATA, and no byte is offered while busy.
  always_comb begin
    state_n  = state_q;
    wr_en_n  = 1'b0;
    rd_en_n  = 1'b0;
    tx_vld_n = 1'b0;
    err_n    = 1'b0;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    txd_n    = txd_q;
    hold_n   = hold_q;
    cnt_n    = cnt_q;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WIDTH'(RF_WR_CMD))      state_n = WR_ADDR;
          else if (RX_P_DATA == WIDTH'(RF_RD_CMD)) state_n = RD_ADDR;
          else                                     err_n   = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_n = RX_P_DATA[ADDR-1:0];
            if (state_q == WR_ADDR) begin
              state_n = WR_DATA;
            end else begin
              rd_en_n = 1'b1;
              cnt_n   = '0;
              state_n = RD_WAIT;
            end
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_n = RX_P_DATA;
          wr_en_n = 1'b1;
          state_n = IDLE;
        end
      end
      RD_WAIT: begin
        // Read data wins over a timeout landing on the same edge.
        if (RF_RdData_VLD) begin
          hold_n = RF_RdData;
          if (!TX_Busy) begin
            txd_n    = RF_RdData;
            tx_vld_n = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n = TX_WAIT;
          end
        end else if (cnt_q == CW'(RD_TIMEOUT)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      TX_WAIT: begin
        if (!TX_Busy) begin
          txd_n    = hold_q;
          tx_vld_n = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wdata_q;
  assign TX_P_DATA  = txd_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Scoreboard bench for rf_cmd_ctrl: command-level reference model predicts every
// strobe/TX/error event with its cycle; a monitor pops and compares them.
module tb_rf_cmd_ctrl;
  import rf_cmd_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ADDR = 4;
  localparam int RD_TIMEOUT = 4;
  localparam int EW = 2 + ADDR + WIDTH + 32;
  localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_TX = 2'd2, EV_ERR = 2'd3;

  logic             CLK, RST;
  logic [WIDTH-1:0] RX_P_DATA;
  logic             RX_D_VLD;
  logic             RF_WrEn, RF_RdEn;
  logic [ADDR-1:0]  RF_Address;
  logic [WIDTH-1:0] RF_WrData, RF_RdData, TX_P_DATA;
  logic             RF_RdData_VLD, TX_D_VLD, TX_Busy, CMD_ERR;
  state_e           dbg_state;

  logic [EW-1:0]    exp_q[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] rf_mem [DEPTH];
  logic [WIDTH-1:0] ref_mem[DEPTH];
  int               rsp_delay = 1;
  int               pend = 0;
  logic [ADDR-1:0]  rsp_addr = '0;

  rf_cmd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy),
    .CMD_ERR(CMD_ERR), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] ev(input logic [1:0] k, input logic [ADDR-1:0] a,
                                       input logic [WIDTH-1:0] d, input int c);
    return {k, a, d, c};
  endfunction

  task automatic push(input logic [1:0] k, input logic [ADDR-1:0] a,
                      input logic [WIDTH-1:0] d, input int c);
    exp_q.push_back(ev(k, a, d, c));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic observe(input string name, input logic [EW-1:0] obs);
    logic [EW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event got %0h want none", name, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", name, obs, e);
      end
    end
  endtask

  // monitor: samples 1ns after the falling edge, away from the active edge
  always @(negedge CLK) begin
    #1;
    if (RF_WrEn || RF_RdEn) check("strobe_excl", 64'(RF_WrEn & RF_RdEn), 64'd0);
    if (RF_WrEn)  observe("wr_event",  ev(EV_WR, RF_Address, RF_WrData, cyc));
    if (RF_RdEn)  observe("rd_event",  ev(EV_RD, RF_Address, '0, cyc));
    if (TX_D_VLD) observe("tx_event",  ev(EV_TX, '0, TX_P_DATA, cyc));
    if (CMD_ERR)  observe("err_event", ev(EV_ERR, '0, '0, cyc));
    if (RF_WrEn) rf_mem[RF_Address] = RF_WrData;
  end

  // register-file responder: valid arrives rsp_delay cycles after the read strobe
  always @(negedge CLK) begin
    RF_RdData_VLD = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        RF_RdData_VLD = 1'b1;
        RF_RdData = rf_mem[rsp_addr];
      end
    end
    if (RF_RdEn) begin
      rsp_addr = RF_Address;
      pend = rsp_delay;
    end
  end

  // driver tasks (called on a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, output int n);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    n = cyc + 1;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
  endtask

  task automatic do_bad(input logic [7:0] b);
    int n;
    send_byte(b, n);
    push(EV_ERR, '0, '0, n);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int n;
    send_byte(RF_WR_CMD, n);
    send_byte(a, n);
    if (a >= DEPTH) begin
      push(EV_ERR, '0, '0, n);
      return;
    end
    send_byte(d, n);
    push(EV_WR, a[ADDR-1:0], d, n);
    ref_mem[a[ADDR-1:0]] = d;
  endtask

  // d = responder latency (0 = never), busy_len = cycles TX_Busy stays high
  task automatic do_read(input logic [7:0] a, input int d, input int busy_len, input bit inject);
    int n, t, r, m;
    rsp_delay = d;
    if (busy_len > 0) TX_Busy = 1'b1;
    send_byte(RF_RD_CMD, n);
    send_byte(a, n);
    if (a >= DEPTH) begin
      push(EV_ERR, '0, '0, n);
      TX_Busy = 1'b0;
      return;
    end
    push(EV_RD, a[ADDR-1:0], '0, n);
    if (d == 0 || d > RD_TIMEOUT) begin
      push(EV_ERR, '0, '0, n + RD_TIMEOUT + 1);
      idle(((d == 0) ? RD_TIMEOUT : d) + 2);
      TX_Busy = 1'b0;
      return;
    end
    t = n + 1 + d;
    for (int k = 0; k < busy_len; k++) begin
      if (inject && $urandom_range(0, 2) == 0) send_byte(8'($urandom), m);
      else idle(1);
    end
    r = cyc;
    TX_Busy = 1'b0;
    if (busy_len > 0 && r + 1 > t) t = r + 1;
    push(EV_TX, '0, ref_mem[a[ADDR-1:0]], t);
    while (cyc < t) idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, 64'({RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR}), 64'd0);
    check({tag, "_addr"}, 64'(RF_Address), 64'd0);
    check({tag, "_wdata"}, 64'(RF_WrData), 64'd0);
    check({tag, "_txdata"}, 64'(TX_P_DATA), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      rf_mem[i] = 8'($urandom);
      ref_mem[i] = rf_mem[i];
    end
    RST = 1'b0;
    RX_P_DATA = '0;
    RX_D_VLD = 1'b0;
    RF_RdData = '0;
    RF_RdData_VLD = 1'b0;
    TX_Busy = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    RST = 1'b1;
    idle(2);

    // directed: write, earliest read, busy read with injected bytes
    do_write(8'h05, 8'h3C);
    do_write(8'h02, 8'h81);
    do_read(8'h02, 1, 0, 1'b0);
    do_write(8'h03, 8'h5A);
    do_read(8'h03, 1, 20, 1'b1);

    // error handling, then normal command
    do_bad(8'h55);
    do_write(8'h1F, 8'h00);
    do_write(8'h07, 8'hC3);
    do_read(8'h07, 2, 0, 1'b0);

    // read timeout, and valid on the last allowed cycle
    do_read(8'h04, 0, 0, 1'b0);
    do_read(8'h04, RD_TIMEOUT, 0, 1'b0);

    // reset between addr and data byte of a write
    send_byte(RF_WR_CMD, n);
    send_byte(8'h05, n);
    RST = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle(2);
    RST = 1'b1;
    idle(1);
    do_write(8'h05, 8'hE7);
    do_read(8'h05, 1, 0, 1'b0);

    // randomized command mix
    for (int i = 0; i < 60; i++) begin
      int sel, r, d;
      logic [7:0] b;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        do_write(8'($urandom_range(0, 19)), 8'($urandom));
      end else if (sel < 8) begin
        r = $urandom_range(0, 9);
        d = (r < 8) ? $urandom_range(1, RD_TIMEOUT) : ((r == 8) ? 0 : $urandom_range(RD_TIMEOUT + 1, 7));
        do_read(8'($urandom_range(0, 18)), d, $urandom_range(0, 6), 1'b1);
      end else begin
        b = 8'($urandom);
        if (b == RF_WR_CMD || b == RF_RD_CMD) b = 8'h00;
        do_bad(b);
      end
      idle($urandom_range(0, 2));
    end

    idle(10);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
